// File: rtl/irq_ctrl.sv
// irq_ctrl: parametrised interrupt controller on the picoRV32 iomem bus.
// Each channel has enable, level/edge mode, polarity and a pending bit.
// The pending bit is write-1-to-clear and is also cleared by a CLAIM read;
// both clears affect edge-mode channels only. irq_out is the OR of
// PENDING & ENABLE.
module irq_ctrl #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iomem_valid,
  output logic               iomem_ready,
  input  logic [3:0]         iomem_wstrb,
  input  logic [31:0]        iomem_addr,
  input  logic [31:0]        iomem_wdata,
  output logic [31:0]        iomem_rdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  // Channel state is held 32 bits wide. Bits at or above NUM_IRQ are forced
  // to zero by CH_MASK, so they read as 0 and ignore writes.
  localparam logic [31:0] CH_MASK =
    (NUM_IRQ >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUM_IRQ) - 32'd1);

  logic [31:0] r_en, r_mode, r_pol, r_pend, r_p;
  logic [SYNC_STAGES-1:0][31:0] r_sync;
  logic        r_ready;
  logic [31:0] r_rdata;

  logic [31:0] w_in, w_s, w_x, w_edge, w_clr, w_pend_nxt, w_act;
  logic [31:0] w_bmask, w_wmask, w_wdm, w_pol_nxt, w_claim_oh, w_rd_val;
  logic        w_hit, w_acc, w_wr, w_rd;
  logic        w_wr_en, w_wr_mode, w_wr_pol, w_wr_pend, w_claim_rd;
  logic        w_cl_vld;
  logic [4:0]  w_cl_idx;

  // Bus decode: a request is accepted only when it falls in the window and
  // no acknowledge is currently showing, which gives one transfer per 2 cycles.
  always_comb begin
    w_hit      = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    w_acc      = w_hit && !r_ready;
    w_wr       = w_acc && (iomem_wstrb != 4'h0);
    w_rd       = w_acc && (iomem_wstrb == 4'h0);
    w_bmask    = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                  {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    w_wmask    = w_bmask & CH_MASK;
    w_wdm      = iomem_wdata & w_wmask;
    w_wr_en    = w_wr && (iomem_addr[7:0] == 8'h00);
    w_wr_mode  = w_wr && (iomem_addr[7:0] == 8'h04);
    w_wr_pol   = w_wr && (iomem_addr[7:0] == 8'h08);
    w_wr_pend  = w_wr && (iomem_addr[7:0] == 8'h0C);
    w_claim_rd = w_rd && (iomem_addr[7:0] == 8'h14);
  end

  // Claim arbitration: the lowest-index active channel wins.
  always_comb begin
    w_act    = r_pend & r_en;
    w_cl_vld = 1'b0;
    w_cl_idx = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_cl_vld = 1'b1;
        w_cl_idx = i[4:0];
      end
    end
    w_claim_oh = w_cl_vld ? (32'd1 << w_cl_idx) : 32'd0;
  end

  // Per-channel datapath. During a POLARITY write edge detection is masked,
  // and p is reloaded with the new polarity so the flip is not seen as an
  // edge on the following cycle. Set beats clear on the same cycle.
  always_comb begin
    w_in                = '0;
    w_in[NUM_IRQ-1:0]   = irq_in;
    w_s                 = r_sync[SYNC_STAGES-1];
    w_x                 = w_s ^ r_pol;
    w_pol_nxt           = w_wr_pol ? ((r_pol & ~w_wmask) | w_wdm) : r_pol;
    w_edge              = w_x & ~r_p & {32{~w_wr_pol}};
    w_clr               = ((w_wr_pend ? w_wdm : 32'd0) |
                           (w_claim_rd ? w_claim_oh : 32'd0)) & r_mode;
    w_pend_nxt          = (~r_mode & w_x) |
                          (r_mode & (w_edge | (r_pend & ~w_clr)));
  end

  // Read mux, sampled into r_rdata on acceptance.
  always_comb begin
    w_rd_val = 32'd0;
    case (iomem_addr[7:0])
      8'h00:   w_rd_val = r_en;
      8'h04:   w_rd_val = r_mode;
      8'h08:   w_rd_val = r_pol;
      8'h0C:   w_rd_val = r_pend;
      8'h10:   w_rd_val = w_act;
      8'h14:   w_rd_val = {w_cl_vld, 26'd0, w_cl_idx};
      8'h18:   w_rd_val = w_s;
      default: w_rd_val = 32'd0;
    endcase
  end

  // Input synchronisers, edge-detect history and pending bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_p    <= '0;
      r_pend <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
      r_p    <= w_wr_pol ? (w_s ^ w_pol_nxt) : w_x;
      r_pend <= w_pend_nxt & CH_MASK;
    end
  end

  // Configuration registers with per-byte write strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en   <= '0;
      r_mode <= '0;
      r_pol  <= '0;
    end else begin
      if (w_wr_en)   r_en   <= (r_en & ~w_wmask) | w_wdm;
      if (w_wr_mode) r_mode <= (r_mode & ~w_wmask) | w_wdm;
      r_pol <= w_pol_nxt;
    end
  end

  // One-cycle acknowledge; read data is zero whenever ready is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_acc;
      r_rdata <= w_acc ? w_rd_val : 32'd0;
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq_out     = |w_act;

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised interrupt controller for the picoRV32 SoC. It replaces the fixed `irq_5`/`irq_6`/`irq_7` wiring with `NUM_IRQ` channels, each individually configurable:

- enable;
- level or edge mode;
- polarity;
- pending state with write-1-to-clear.

It sits on the iomem bus beside the port peripherals. Its single `irq_out` drives one CPU IRQ line, and firmware identifies the source through a claim register.

## Interface
Parameters:
- `NUM_IRQ`, 8: number of channels, 1..32.
- `BASE_ADDR`, 32'h0300_0000: register window base, 256-byte aligned.
- `SYNC_STAGES`, 2: synchroniser depth on `irq_in`, 2..3.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iomem_valid`  in  1  bus request; held until `iomem_ready`.
- `iomem_ready`  out  1  one-cycle acknowledge.
- `iomem_wstrb`  in  4  byte write strobes; 0 means read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data, valid while `iomem_ready`=1.
- `irq_in`  in  NUM_IRQ  asynchronous interrupt sources.
- `irq_out`  out  1  OR of the ACTIVE register.

## Operation
Register map (word offsets from `BASE_ADDR`; bits ≥ `NUM_IRQ` read 0 and ignore writes):
- 0x00 ENABLE, RW.
- 0x04 MODE, RW: 0 = level, 1 = edge.
- 0x08 POLARITY, RW: 0 = active-high/rising, 1 = active-low/falling.
- 0x0C PENDING: read; write-1-to-clear, effective on edge-mode channels only.
- 0x10 ACTIVE, RO: PENDING & ENABLE.
- 0x14 CLAIM, RO: bit31 = valid, [4:0] = lowest-index active channel, 0 if none.
  - Read side effect: clears PENDING of the claimed channel if it is edge-mode.
- 0x18 RAW, RO: synchronised `irq_in`.
- Other in-window offsets: read 0, writes ignored, still acknowledged.

Register writes honour `iomem_wstrb` per byte.

Addresses outside `[BASE_ADDR, BASE_ADDR+0xFF]` are never acknowledged; `iomem_ready` stays 0 so another slave can respond.

Per-channel datapath:
- `s` = synchroniser output.
- `x` = `s` XOR `POLARITY[i]`; `p` = `x` registered one cycle.
- Level mode: PENDING[i] <= `x` every cycle.
- Edge mode: PENDING[i] is set on `x & ~p`; it is cleared only by W1C or CLAIM.

Rules at boundaries and simultaneous events:
- Edge detect coinciding with a W1C or CLAIM clear of the same channel: set wins; no event is lost.
- Cycle of a POLARITY write: edge detection is masked on all channels, so a polarity flip causes no spurious edge.
- Switching MODE from level to edge keeps the current PENDING value.
- Disabled channels still latch PENDING; they are masked only from ACTIVE, CLAIM and `irq_out`.
- An input already asserted at reset release registers as an edge once it has propagated through the synchroniser.

## Timing
Reset state: all registers 0, including synchronisers and `p`, so `irq_out`=0, `iomem_ready`=0 and `iomem_rdata`=0.
- Reset asserted mid-transaction aborts it; no acknowledge is issued.

Input latency: an `irq_in` transition reaches `s` after `SYNC_STAGES` edges, and PENDING after `SYNC_STAGES`+1 edges.
- `irq_out` is combinational from PENDING & ENABLE, so with defaults it rises after the 3rd edge.

Bus handshake:
- `iomem_valid` and in-window address seen at edge N with `iomem_ready`=0: `iomem_ready`=1 after edge N, with `iomem_rdata` loaded.
- `iomem_ready` returns to 0 after edge N+1.
- `iomem_rdata` returns to 0 whenever `iomem_ready`=0.
- Writes and CLAIM side effects take effect at edge N.
- Back-to-back transactions complete one every 2 cycles.

## Test plan
1. After reset, read all 7 registers → all return 0 and `irq_out`=0.
2. ENABLE=0xFF, MODE=0x00, `irq_in[3]` high → `irq_out`=1 three edges later, ACTIVE=0x08, CLAIM=0x8000_0003; drop `irq_in[3]` → `irq_out`=0 three edges later.
3. MODE=0xFF, 40 ns pulse on `irq_in[5]` → PENDING=0x20 held after the pulse; W1C 0x20 → PENDING=0 and `irq_out`=0 the next cycle.
4. Edge mode, `irq_in[1]` and `irq_in[6]` both pulsed → first CLAIM returns 0x8000_0001, second 0x8000_0006, third 0x0000_0000.
5. Rising edge on channel 2 arrives in the same cycle as a W1C of bit 2 → PENDING[2]=1 afterwards. A POLARITY=0x04 write while `irq_in[2]`=0 → no PENDING set.
6. Write to `BASE_ADDR`+0x100 → `iomem_ready` never asserts. `iomem_wstrb`=0x1, data 0xFFFF_FFFF to ENABLE → ENABLE=0x0000_00FF. Reset asserted while `iomem_valid` is high → `iomem_ready`=0.
